// File: rtl/pwm_output_stage.sv
// 16-channel output stage: each pin forced low, static high, or driven by a shared 8-bit PWM.
// Duty and PWM-select are shadowed at the period boundary so pulses are never truncated.
module pwm_output_stage #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  logic [PreW-1:0] pre_q, pre_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      duty_sh_q, duty_sh_d;
  logic [15:0]     pwm_sh_q, pwm_sh_d;
  logic [15:0]     out_q, out_d;
  logic [15:0]     en_out, en_pwm;
  logic            tick, bnd, pwm_raw;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick      = (pre_q == PreMax);
    pre_d     = tick ? '0 : pre_q + 1'b1;
    cnt_d     = tick ? cnt_q + 8'd1 : cnt_q;
    bnd       = tick && (cnt_q == 8'hFF);
    duty_sh_d = bnd ? pwm_duty_cycle : duty_sh_q;
    pwm_sh_d  = bnd ? en_pwm : pwm_sh_q;
    // 0xFF means fully on, not 255/256.
    pwm_raw   = (duty_sh_q == 8'hFF) || (cnt_q < duty_sh_q);
    // en_out is deliberately not shadowed: disabling a pin acts on the next edge.
    out_d     = en_out & (~pwm_sh_q | {16{pwm_raw}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      duty_sh_q <= '0;
      pwm_sh_q  <= '0;
      out_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      duty_sh_q <= duty_sh_d;
      pwm_sh_q  <= pwm_sh_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with PRESCALE = 2 (512-cycle period).
// cyc counts clock edges since the last reset release; out in cycle c reflects state of c-1.
module tb_pwm_output_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;

  int cyc;
  int n_assert;
  int n_fail;

  pwm_output_stage #(.PRESCALE(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cyc %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hi0, hi3;
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    en_out   = 16'hFFFF;
    en_pwm   = 16'hFFFF;
    duty     = 8'hFF;
    rst_n    = 1'b1;

    // 1. Reset: asynchronous clear, no clock edge between assert and check.
    #2 rst_n = 1'b0;
    #1 chk16("reset_async_init", out, 16'h0000);
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    step();
    chk16("first_period_static", out, 16'hFFFF);
    goto(100);
    chk16("pre_reset_high", out, 16'hFFFF);
    rst_n = 1'b0;
    #1 chk16("reset_mid_period", out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk16("reset_held", out, 16'h0000);
    end
    rst_n = 1'b1;
    cyc   = 0;
    duty  = 8'h00;
    step();
    chk16("post_reset_static", out, 16'hFFFF);
    goto(511);
    chk16("before_bnd_511", out, 16'hFFFF);
    step();
    chk16("bnd_cycle_512", out, 16'hFFFF);
    step();
    chk16("after_bnd_513", out, 16'h0000);

    // 2. Static enables (pwm select cleared from the boundary at 1023).
    en_pwm = 16'h0000;
    en_out = 16'h0000;
    goto(1100);
    chk16("static_all_off", out, 16'h0000);
    en_out = 16'h0005;
    step();
    chk16("static_en_0005", out, 16'h0005);
    goto(1110);
    chk16("static_hold_0005", out, 16'h0005);
    en_out = 16'h0000;
    step();
    chk16("static_disable_mid", out, 16'h0000);

    // 3. 50% duty; en_pwm written mid-period must not apply until cycle 1536.
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'h80;
    goto(1200);
    chk16("pwm_sel_deferred_a", out, 16'hFFFF);
    goto(1400);
    chk16("pwm_sel_deferred_b", out, 16'hFFFF);
    goto(1536);
    for (int p = 0; p < 3; p++) begin
      hi0 = 0;
      for (int k = 0; k < 512; k++) begin
        step();
        chk16("duty50_wave", out, (k < 256) ? 16'hFFFF : 16'h0000);
        if (out[0]) hi0++;
      end
      chk_int("duty50_high_width", hi0, 256);
    end

    // 4. Extremes: 0x00 constant low, 0xFF constant high.
    duty = 8'h00;
    goto(3584);
    for (int k = 0; k < 1024; k++) begin
      step();
      chk16("duty00_low", out, 16'h0000);
    end
    duty = 8'hFF;
    goto(5120);
    for (int k = 0; k < 1024; k++) begin
      step();
      chk16("dutyFF_high", out, 16'hFFFF);
    end

    // 5. Glitch-free update: write 0xC0 and drop pwm bit 3 at cnt 0x10 (cycle 6688).
    duty = 8'h40;
    goto(6656);
    hi0 = 0;
    hi3 = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      if (cyc == 6688) begin
        duty   = 8'hC0;
        en_pwm = 16'hFFF7;
      end
      chk16("update_cur_period", out, (k < 128) ? 16'hFFFF : 16'h0000);
      if (out[0]) hi0++;
      if (out[3]) hi3++;
    end
    chk_int("update_cur_width", hi0, 128);
    chk_int("update_cur_bit3", hi3, 128);
    hi0 = 0;
    hi3 = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      chk16("update_next_period", out, (k < 384) ? 16'hFFFF : 16'h0008);
      if (out[0]) hi0++;
      if (out[3]) hi3++;
    end
    chk_int("update_next_width", hi0, 384);
    chk_int("update_next_bit3", hi3, 512);

    // 6. Mixed: pwm on [3:0], static high on [7:4], off on [15:8].
    en_out = 16'h00FF;
    en_pwm = 16'h000F;
    duty   = 8'h20;
    goto(8192);
    hi0 = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      chk16("mixed_wave", out, (k < 64) ? 16'h00FF : 16'h00F0);
      if (out[0]) hi0++;
    end
    chk_int("mixed_width", hi0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
